// File: rtl/addlist_feeder_if.sv
// addlist_feeder_if: memory read port plus 4-word group handshake between feeder and list adder.
interface addlist_feeder_if #(parameter int ADDR_W = 16);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              data_request;
    logic              data_available;
    logic [3:0][31:0]  buffer;
    logic              last;
    modport master (
        output mem_rd, mem_addr, data_available, buffer, last,
        input  mem_data, data_request
    );
    modport slave (
        input  mem_rd, mem_addr, data_available, buffer, last,
        output mem_data, data_request
    );
endinterface

// File: rtl/addlist_feeder.sv
// addlist_feeder: fetches a word list from sync-read memory and presents it as zero-padded 4-word groups.
module addlist_feeder #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    addlist_feeder_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [2:0]        cyc;
    logic              req_q;
    logic              consume;
    logic [2:0]        issue_k;
    logic [2:0]        cap_k;
    logic              issue_v;
    logic              cap_v;
    logic [LEN_W-1:0]  rem_next;
    // cyc counts cycles since entering FETCH: slot cyc+1 is issued, slot cyc-1 is captured
    assign issue_k  = cyc + 3'd1;
    assign cap_k    = cyc - 3'd1;
    assign issue_v  = rem > LEN_W'(issue_k);
    assign cap_v    = rem > LEN_W'(cap_k);
    assign rem_next = rem > LEN_W'(4) ? rem - LEN_W'(4) : '0;
    assign consume  = bus.data_request & ~req_q;
    assign busy     = state == FETCH || state == READY;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            addr               <= '0;
            rem                <= '0;
            cyc                <= '0;
            req_q              <= 1'b0;
            done               <= 1'b0;
            bus.mem_rd         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.data_available <= 1'b0;
            bus.buffer         <= '0;
            bus.last           <= 1'b0;
        end else begin
            req_q <= bus.data_request;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr <= base_addr;
                        rem  <= length;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            done         <= 1'b0;
                            cyc          <= '0;
                            bus.mem_rd   <= 1'b1;
                            bus.mem_addr <= base_addr;
                        end
                    end
                end
                FETCH: begin
                    cyc <= cyc + 3'd1;
                    if (cyc < 3'd3) begin
                        bus.mem_rd <= issue_v;
                        if (issue_v)
                            bus.mem_addr <= addr + ADDR_W'(issue_k);
                    end else begin
                        bus.mem_rd <= 1'b0;
                    end
                    if (cyc != 3'd0)
                        bus.buffer[cap_k[1:0]] <= cap_v ? bus.mem_data : 32'd0;
                    if (cyc == 3'd4) begin
                        state              <= READY;
                        bus.data_available <= 1'b1;
                        bus.last           <= rem <= LEN_W'(4);
                        addr               <= addr + ADDR_W'(4);
                        rem                <= rem_next;
                    end
                end
                READY: begin
                    if (consume) begin
                        bus.data_available <= 1'b0;
                        if (rem != '0) begin
                            state        <= FETCH;
                            cyc          <= '0;
                            bus.mem_rd   <= 1'b1;
                            bus.mem_addr <= addr;
                        end else begin
                            state    <= DONE;
                            bus.last <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
